// File: rtl/fetch_redirect_unit_if.sv
// Fetch-stage <-> IF/ID redirect unit signal bundle.
// The fetch side drives the instruction stream; the unit drives the ID slot and redirect buses.
interface fetch_redirect_unit_if;
  logic [15:0] instruction;
  logic [15:0] NPC;
  logic        flush;
  logic        cond_true;
  logic [15:0] instruction_id;
  logic [15:0] NPC_id;
  logic        valid_id;
  logic [1:0]  PCsrc;
  logic [15:0] J_TypeImmediate;
  logic [15:0] I_TypeImmediate;
  logic [15:0] ReturnAddress;
  logic        ras_overflow;
  logic        ras_underflow;

  modport master (
    output instruction, NPC, flush, cond_true,
    input  instruction_id, NPC_id, valid_id, PCsrc, J_TypeImmediate,
           I_TypeImmediate, ReturnAddress, ras_overflow, ras_underflow
  );

  modport slave (
    input  instruction, NPC, flush, cond_true,
    output instruction_id, NPC_id, valid_id, PCsrc, J_TypeImmediate,
           I_TypeImmediate, ReturnAddress, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/fetch_redirect_unit.sv
// IF/ID pipeline register with early jump/call/return/branch redirect
// and a circular return-address stack.
module fetch_redirect_unit #(
  parameter int unsigned RAS_DEPTH = 4,
  parameter logic [3:0]  OP_BR     = 4'h8,
  parameter logic [3:0]  OP_JMP    = 4'hA,
  parameter logic [3:0]  OP_CALL   = 4'hB,
  parameter logic [3:0]  OP_RET    = 4'hC,
  parameter logic [15:0] NOP       = 16'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  fetch_redirect_unit_if.slave  bus
);

  localparam int unsigned XLEN  = 16;
  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_J   = 2'b01;
  localparam logic [1:0] PC_I   = 2'b10;
  localparam logic [1:0] PC_RA  = 2'b11;

  // ID slot and RAS state
  logic [XLEN-1:0]  instr_q, instr_d;
  logic [XLEN-1:0]  npc_q, npc_d;
  logic             valid_q, valid_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  ras_q [RAS_DEPTH];
  logic [XLEN-1:0]  ras_d [RAS_DEPTH];
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [3:0]       op_c;
  logic [1:0]       pcsrc_c;
  logic             push_c;
  logic             pop_c;
  logic             ret_empty_c;
  logic             ras_empty_c;
  logic             ras_full_c;
  logic [PTR_W-1:0] top_idx_c;
  logic [XLEN-1:0]  i_off_c;

  assign op_c        = instr_q[15:12];
  assign ras_empty_c = (cnt_q == '0);
  assign ras_full_c  = (cnt_q == CNT_W'(RAS_DEPTH));
  assign top_idx_c   = ptr_q - PTR_W'(1);
  assign i_off_c     = {{9{instr_q[5]}}, instr_q[5:0], 1'b0};

  // Redirect decode; a flushed or reset-cycle ID instruction is dead.
  always_comb begin
    pcsrc_c     = PC_SEQ;
    push_c      = 1'b0;
    pop_c       = 1'b0;
    ret_empty_c = 1'b0;
    if (!reset && valid_q && !bus.flush) begin
      if (op_c == OP_JMP) begin
        pcsrc_c = PC_J;
      end else if (op_c == OP_CALL) begin
        pcsrc_c = PC_J;
        push_c  = 1'b1;
      end else if (op_c == OP_BR) begin
        pcsrc_c = bus.cond_true ? PC_I : PC_SEQ;
      end else if (op_c == OP_RET) begin
        if (ras_empty_c) begin
          ret_empty_c = 1'b1;
        end else begin
          pcsrc_c = PC_RA;
          pop_c   = 1'b1;
        end
      end
    end
  end

  // Next ID slot: flush, then redirect squash, then normal load.
  always_comb begin
    instr_d = bus.instruction;
    npc_d   = bus.NPC;
    valid_d = 1'b1;
    if (bus.flush || (pcsrc_c != PC_SEQ)) begin
      instr_d = NOP;
      npc_d   = '0;
      valid_d = 1'b0;
    end
  end

  // Next RAS state; a push while full overwrites the oldest slot at ptr_q.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ras_d = ras_q;
    ovf_d = 1'b0;
    unf_d = unf_q | ret_empty_c;
    if (push_c) begin
      ras_d[ptr_q] = npc_q;
      ptr_d        = ptr_q + PTR_W'(1);
      if (ras_full_c) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (pop_c) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= NOP;
      npc_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        ras_q[i] <= '0;
      end
    end else begin
      instr_q <= instr_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      ras_q   <= ras_d;
    end
  end

  assign bus.instruction_id  = instr_q;
  assign bus.NPC_id          = npc_q;
  assign bus.valid_id        = valid_q;
  assign bus.PCsrc           = pcsrc_c;
  assign bus.J_TypeImmediate = {npc_q[15:13], instr_q[11:0], 1'b0};
  assign bus.I_TypeImmediate = npc_q + i_off_c;
  assign bus.ReturnAddress   = ras_empty_c ? '0 : ras_q[top_idx_c];
  assign bus.ras_overflow    = ovf_q;
  assign bus.ras_underflow   = unf_q;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Per-cycle vector bench for fetch_redirect_unit: each record gives this cycle's
// inputs and the outputs expected before the next rising edge.
module tb_fetch_redirect_unit;

  logic clk;
  logic reset;

  fetch_redirect_unit_if bus ();

  fetch_redirect_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic [15:0] ins;
    logic [15:0] npc;
    bit          fl;
    bit          cnd;
    bit          chk;
    bit          ev;
    logic [1:0]  epc;
    logic [15:0] era;
    bit          eo;
    bit          eu;
    int          sel;   // 0 none, 1 J imm, 2 I imm, 3 instruction_id
    logic [15:0] eimm;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic vec_t mk(bit rst, logic [15:0] ins, logic [15:0] npc, bit fl, bit cnd,
                              bit chk, bit ev, logic [1:0] epc, logic [15:0] era,
                              bit eo, bit eu, int sel, logic [15:0] eimm);
    vec_t v;
    v.rst = rst; v.ins = ins; v.npc = npc; v.fl = fl; v.cnd = cnd; v.chk = chk;
    v.ev = ev; v.epc = epc; v.era = era; v.eo = eo; v.eu = eu; v.sel = sel; v.eimm = eimm;
    return v;
  endfunction

  task automatic cmp(string name, int idx, logic [15:0] act, logic [15:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL vec %0d %s: got %h expected %h", idx, name, act, exp);
    end
  endtask

  // Scoreboard check: pops the expectation queued when the cycle was driven.
  task automatic check_front(int idx);
    vec_t e;
    e = sb.pop_front();
    vectors++;
    cmp("PCsrc", idx, 16'(bus.PCsrc), 16'(e.epc));
    if (e.chk) begin
      cmp("valid_id", idx, 16'(bus.valid_id), 16'(e.ev));
      cmp("ReturnAddress", idx, bus.ReturnAddress, e.era);
      cmp("ras_overflow", idx, 16'(bus.ras_overflow), 16'(e.eo));
      cmp("ras_underflow", idx, 16'(bus.ras_underflow), 16'(e.eu));
      case (e.sel)
        1: cmp("J_TypeImmediate", idx, bus.J_TypeImmediate, e.eimm);
        2: cmp("I_TypeImmediate", idx, bus.I_TypeImmediate, e.eimm);
        3: cmp("instruction_id", idx, bus.instruction_id, e.eimm);
        default: ;
      endcase
    end
  endtask

  // Drive one cycle's inputs away from the rising edge, then sample before it.
  task automatic apply(vec_t v, int idx);
    @(negedge clk);
    reset           = v.rst;
    bus.instruction = v.ins;
    bus.NPC         = v.npc;
    bus.flush       = v.fl;
    bus.cond_true   = v.cnd;
    sb.push_back(v);
    #2;
    check_front(idx);
  endtask

  initial begin
    reset           = 1'b1;
    bus.instruction = 16'h0;
    bus.NPC         = 16'h0;
    bus.flush       = 1'b0;
    bus.cond_true   = 1'b0;

    // Reset and NOP stream
    tbl.push_back(mk(1, 16'h0000, 16'h0000, 0, 0, 0, 0, 2'd0, 16'h0000, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(1, 16'h0000, 16'h0000, 0, 0, 1, 0, 2'd0, 16'h0000, 0, 0, 3, 16'h0000));
    tbl.push_back(mk(0, 16'h0000, 16'h0002, 0, 0, 1, 0, 2'd0, 16'h0000, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 16'h0000, 16'h0004, 0, 0, 1, 1, 2'd0, 16'h0000, 0, 0, 3, 16'h0000));
    // Jump, then squashed wrong-path slot
    tbl.push_back(mk(0, 16'hA005, 16'h0012, 0, 0, 1, 1, 2'd0, 16'h0000, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 16'h1234, 16'h0014, 0, 0, 1, 1, 2'd1, 16'h0000, 0, 0, 1, 16'h000A));
    tbl.push_back(mk(0, 16'h803E, 16'h0020, 0, 0, 1, 0, 2'd0, 16'h0000, 0, 0, 3, 16'h0000));
    // Taken branch, then not-taken branch with no squash
    tbl.push_back(mk(0, 16'h1111, 16'h0022, 0, 1, 1, 1, 2'd2, 16'h0000, 0, 0, 2, 16'h001C));
    tbl.push_back(mk(0, 16'h803E, 16'h0020, 0, 0, 1, 0, 2'd0, 16'h0000, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 16'h2222, 16'h0022, 0, 0, 1, 1, 2'd0, 16'h0000, 0, 0, 2, 16'h001C));
    // CALL then RET
    tbl.push_back(mk(0, 16'hB100, 16'h0040, 0, 0, 1, 1, 2'd0, 16'h0000, 0, 0, 3, 16'h2222));
    tbl.push_back(mk(0, 16'h3333, 16'h0042, 0, 0, 1, 1, 2'd1, 16'h0000, 0, 0, 1, 16'h0200));
    tbl.push_back(mk(0, 16'hC000, 16'h0202, 0, 0, 1, 0, 2'd0, 16'h0040, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 16'h4444, 16'h0204, 0, 0, 1, 1, 2'd3, 16'h0040, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 16'h0000, 16'h0042, 0, 0, 1, 0, 2'd0, 16'h0000, 0, 0, 0, 16'h0000));
    // Five CALLs into a depth-4 stack
    tbl.push_back(mk(0, 16'hB000, 16'h0010, 0, 0, 1, 1, 2'd0, 16'h0000, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 16'h5555, 16'h0012, 0, 0, 1, 1, 2'd1, 16'h0000, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 16'hB000, 16'h0020, 0, 0, 1, 0, 2'd0, 16'h0010, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 16'h5555, 16'h0022, 0, 0, 1, 1, 2'd1, 16'h0010, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 16'hB000, 16'h0030, 0, 0, 1, 0, 2'd0, 16'h0020, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 16'h5555, 16'h0032, 0, 0, 1, 1, 2'd1, 16'h0020, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 16'hB000, 16'h0040, 0, 0, 1, 0, 2'd0, 16'h0030, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 16'h5555, 16'h0042, 0, 0, 1, 1, 2'd1, 16'h0030, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 16'hB000, 16'h0050, 0, 0, 1, 0, 2'd0, 16'h0040, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 16'h5555, 16'h0052, 0, 0, 1, 1, 2'd1, 16'h0040, 0, 0, 0, 16'h0000));
    // Overflow pulse, then four RETs and one into an empty stack
    tbl.push_back(mk(0, 16'hC000, 16'h0054, 0, 0, 1, 0, 2'd0, 16'h0050, 1, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 16'h5555, 16'h0056, 0, 0, 1, 1, 2'd3, 16'h0050, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 16'hC000, 16'h0058, 0, 0, 1, 0, 2'd0, 16'h0040, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 16'h5555, 16'h005A, 0, 0, 1, 1, 2'd3, 16'h0040, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 16'hC000, 16'h005C, 0, 0, 1, 0, 2'd0, 16'h0030, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 16'h5555, 16'h005E, 0, 0, 1, 1, 2'd3, 16'h0030, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 16'hC000, 16'h0060, 0, 0, 1, 0, 2'd0, 16'h0020, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 16'h5555, 16'h0062, 0, 0, 1, 1, 2'd3, 16'h0020, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 16'hC000, 16'h0064, 0, 0, 1, 0, 2'd0, 16'h0000, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 16'h0000, 16'h0066, 0, 0, 1, 1, 2'd0, 16'h0000, 0, 0, 0, 16'h0000));
    // Sticky underflow, flush kills a CALL in ID
    tbl.push_back(mk(0, 16'hB000, 16'h0070, 0, 0, 1, 1, 2'd0, 16'h0000, 0, 1, 3, 16'h0000));
    tbl.push_back(mk(0, 16'h6666, 16'h0072, 1, 0, 1, 1, 2'd0, 16'h0000, 0, 1, 3, 16'hB000));
    tbl.push_back(mk(0, 16'h0000, 16'h0074, 0, 0, 1, 0, 2'd0, 16'h0000, 0, 1, 3, 16'h0000));
    tbl.push_back(mk(0, 16'hB000, 16'h0080, 0, 0, 1, 1, 2'd0, 16'h0000, 0, 1, 0, 16'h0000));
    // Reset with a CALL in ID: no redirect, no push, flags cleared
    tbl.push_back(mk(1, 16'h0000, 16'h0082, 0, 0, 1, 1, 2'd0, 16'h0000, 0, 1, 3, 16'hB000));
    tbl.push_back(mk(0, 16'h0000, 16'h0002, 0, 0, 1, 0, 2'd0, 16'h0000, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 16'h0000, 16'h0004, 0, 0, 1, 1, 2'd0, 16'h0000, 0, 0, 0, 16'h0000));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], i);
    end

    // Flushed RET must not pop; the following RET still returns 0x0090.
    apply(mk(0, 16'hB000, 16'h0090, 0, 0, 1, 1, 2'd0, 16'h0000, 0, 0, 0, 16'h0000), 100);
    apply(mk(0, 16'h7777, 16'h0092, 0, 0, 1, 1, 2'd1, 16'h0000, 0, 0, 0, 16'h0000), 101);
    apply(mk(0, 16'hC000, 16'h0094, 0, 0, 1, 0, 2'd0, 16'h0090, 0, 0, 0, 16'h0000), 102);
    apply(mk(0, 16'h7777, 16'h0096, 1, 0, 1, 1, 2'd0, 16'h0090, 0, 0, 0, 16'h0000), 103);
    apply(mk(0, 16'hC000, 16'h0098, 0, 0, 1, 0, 2'd0, 16'h0090, 0, 0, 0, 16'h0000), 104);
    apply(mk(0, 16'h7777, 16'h009A, 0, 0, 1, 1, 2'd3, 16'h0090, 0, 0, 0, 16'h0000), 105);
    // Flush overrides a taken branch in the same cycle.
    apply(mk(0, 16'h803E, 16'h0020, 0, 0, 1, 0, 2'd0, 16'h0000, 0, 0, 0, 16'h0000), 106);
    apply(mk(0, 16'h1111, 16'h0022, 1, 1, 1, 1, 2'd0, 16'h0000, 0, 0, 2, 16'h001C), 107);
    apply(mk(0, 16'h0000, 16'h0024, 0, 0, 1, 0, 2'd0, 16'h0000, 0, 0, 3, 16'h0000), 108);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
